// File: rtl/sram_phase_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_phase_arbiter                                              |
// | Purpose  : SRAM bus owner/sequencer. Client 0 (VGA) owns the bus by        |
// |            default for reads. One Start pulse runs the enabled phases      |
// |            1..NUM_CLIENTS-1 in ascending order. Each phase keeps the bus   |
// |            until it reports done, or until a timer expires if it is       |
// |            configured to end on inactivity. The address, write data and    |
// |            write enable all come from one registered owner index, so they  |
// |            always refer to the same client.                                |
// | Ports    : Clock, Resetn (async, active low)                               |
// |            Start, Abort          - single-cycle sequence controls          |
// |            Phase_enable         - bit i includes phase i (bit 0 ignored)   |
// |            Client_address/_write_data/_we_n - packed per-client bus        |
// |            Client_done          - per-client completion pulse             |
// |            Client_start         - one-cycle start pulse to a client       |
// |            Grant                - one-hot current owner                   |
// |            SRAM_address/_write_data/_we_n - muxed bus to SRAM controller   |
// |            Busy, All_done, Aborted - sequence status                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_phase_arbiter #(
  parameter int                     NUM_CLIENTS    = 4,
  parameter int                     ADDR_W         = 18,
  parameter int                     DATA_W         = 16,
  parameter int                     TIMEOUT_W      = 26,
  parameter int                     TIMEOUT_CYCLES = 49999999,
  parameter logic [NUM_CLIENTS-1:0] TIMEOUT_MASK   = 4'b0010
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          Start,
  input  logic                          Abort,
  input  logic [NUM_CLIENTS-1:0]        Phase_enable,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] Client_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0] Client_write_data,
  input  logic [NUM_CLIENTS-1:0]        Client_we_n,
  input  logic [NUM_CLIENTS-1:0]        Client_done,
  output logic [NUM_CLIENTS-1:0]        Client_start,
  output logic [NUM_CLIENTS-1:0]        Grant,
  output logic [ADDR_W-1:0]             SRAM_address,
  output logic [DATA_W-1:0]             SRAM_write_data,
  output logic                          SRAM_we_n,
  output logic                          Busy,
  output logic                          All_done,
  output logic                          Aborted
);

  localparam int                   c_owner_w = $clog2(NUM_CLIENTS);
  localparam logic [TIMEOUT_W-1:0] c_timeout = TIMEOUT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                 r_state,      w_state_nxt;
  logic [c_owner_w-1:0]   r_owner,      w_owner_nxt;
  logic [TIMEOUT_W-1:0]   r_timer,      w_timer_nxt;
  logic                   r_all_done,   w_all_done_nxt;
  logic                   r_aborted,    w_aborted_nxt;

  logic                   w_nxt_valid;
  logic [c_owner_w-1:0]   w_nxt;
  logic                   w_phase_end;
  logic [NUM_CLIENTS-1:0] w_grant;

  // Phase_enable[0] has no meaning: client 0 is never sequenced.
  logic w_unused_ok;
  assign w_unused_ok = Phase_enable[0];

  // Unpack the flat client buses so the owner index can select directly.
  logic [ADDR_W-1:0] w_addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0] w_wdata_arr [NUM_CLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = Client_address[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = Client_write_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Bus mux: everything keyed on the single owner register.
  assign SRAM_address    = w_addr_arr[r_owner];
  assign SRAM_write_data = (r_owner == '0) ? '0   : w_wdata_arr[r_owner];
  assign SRAM_we_n       = (r_owner == '0) ? 1'b1 : Client_we_n[r_owner];

  always_comb begin
    w_grant          = '0;
    w_grant[r_owner] = 1'b1;
  end

  assign Grant        = w_grant;
  assign Client_start = (r_state == S_START) ? w_grant : '0;
  assign Busy         = (r_state != S_IDLE);
  assign All_done     = r_all_done;
  assign Aborted      = r_aborted;

  // Lowest enabled phase above the current owner. In idle the owner is 0,
  // so the same search yields the first enabled phase of the sequence.
  always_comb begin
    w_nxt_valid = 1'b0;
    w_nxt       = '0;
    for (int i = NUM_CLIENTS - 1; i >= 1; i--) begin
      if (Phase_enable[i] && (i > int'(r_owner))) begin
        w_nxt_valid = 1'b1;
        w_nxt       = i[c_owner_w-1:0];
      end
    end
  end

  // A timeout-terminated phase ignores its done line, so a coincident done
  // and timeout can only ever produce one phase end.
  assign w_phase_end = TIMEOUT_MASK[r_owner] ? (r_timer == c_timeout)
                                             : Client_done[r_owner];

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_timer_nxt    = r_timer;
    w_all_done_nxt = 1'b0;
    w_aborted_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_owner_nxt = '0;
        w_timer_nxt = '0;
        if (Start && !Abort) begin
          if (w_nxt_valid) begin
            w_state_nxt = S_START;
            w_owner_nxt = w_nxt;
          end else begin
            w_all_done_nxt = 1'b1;
          end
        end
      end

      S_START: begin
        w_timer_nxt = '0;
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        // Any write by the owner counts as activity; saturate, never wrap.
        if (!Client_we_n[r_owner]) begin
          w_timer_nxt = '0;
        end else if (r_timer != c_timeout) begin
          w_timer_nxt = r_timer + TIMEOUT_W'(1);
        end

        if (w_phase_end) begin
          w_timer_nxt = '0;
          if (w_nxt_valid) begin
            w_state_nxt = S_START;
            w_owner_nxt = w_nxt;
          end else begin
            w_state_nxt    = S_IDLE;
            w_owner_nxt    = '0;
            w_all_done_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = '0;
        w_timer_nxt = '0;
      end
    endcase

    // Abort overrides everything outside idle, including a phase end.
    if (Abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_owner_nxt    = '0;
      w_timer_nxt    = '0;
      w_all_done_nxt = 1'b0;
      w_aborted_nxt  = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_timer    <= '0;
      r_all_done <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_timer    <= w_timer_nxt;
      r_all_done <= w_all_done_nxt;
      r_aborted  <= w_aborted_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_phase_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_phase_arbiter                                           |
// | Purpose  : Self-checking bench for sram_phase_arbiter (4 clients,          |
// |            10-cycle timeout on phase 1).                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_phase_arbiter;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 16;

  logic            CLOCK_50_I = 1'b0;
  logic            resetn;
  logic            start;
  logic            abort;
  logic [N-1:0]    phase_enable;
  logic [N*AW-1:0] client_address;
  logic [N*DW-1:0] client_write_data;
  logic [N-1:0]    client_we_n;
  logic [N-1:0]    client_done;
  logic [N-1:0]    client_start;
  logic [N-1:0]    grant;
  logic [AW-1:0]   sram_address;
  logic [DW-1:0]   sram_write_data;
  logic            sram_we_n;
  logic            busy;
  logic            all_done;
  logic            aborted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  sram_phase_arbiter #(
    .NUM_CLIENTS    (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_W      (26),
    .TIMEOUT_CYCLES (10),
    .TIMEOUT_MASK   (4'b0010)
  ) dut (
    .Clock             (CLOCK_50_I),
    .Resetn            (resetn),
    .Start             (start),
    .Abort             (abort),
    .Phase_enable      (phase_enable),
    .Client_address    (client_address),
    .Client_write_data (client_write_data),
    .Client_we_n       (client_we_n),
    .Client_done       (client_done),
    .Client_start      (client_start),
    .Grant             (grant),
    .SRAM_address      (sram_address),
    .SRAM_write_data   (sram_write_data),
    .SRAM_we_n         (sram_we_n),
    .Busy              (busy),
    .All_done          (all_done),
    .Aborted           (aborted)
  );

  typedef struct packed {
    logic       start;
    logic       abort;
    logic [3:0] en;
    logic [3:0] we_n;
    logic [3:0] done;
    logic [3:0] exp_cs;
    logic [3:0] exp_grant;
    logic       exp_busy;
    logic       exp_all_done;
    logic       exp_aborted;
  } vec_t;

  vec_t vecs [64];
  int   n_vecs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] status();
    return {client_start, grant, busy, all_done, aborted};
  endfunction

  task automatic add_vec(input logic s, input logic a, input logic [3:0] en,
                         input logic [3:0] we, input logic [3:0] dn,
                         input logic [3:0] cs, input logic [3:0] gr,
                         input logic b, input logic ad, input logic ab);
    vecs[n_vecs] = {s, a, en, we, dn, cs, gr, b, ad, ab};
    n_vecs++;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic quiet();
    start       = 1'b0;
    abort       = 1'b0;
    client_done = 4'b0000;
    client_we_n = 4'hF;
  endtask

  initial begin
    logic [3:0] e_cs;
    logic [3:0] e_gr;
    logic       e_ad;

    resetn            = 1'b0;
    phase_enable      = 4'b0000;
    client_address    = {18'h2AAAA, 18'h01234, 18'h00111, 18'h3FFFF};
    client_write_data = {16'h3333, 16'hBEEF, 16'h1111, 16'hAAAA};
    quiet();

    // Expected outputs refer to the state after the edge that samples the row.
    //       st    ab    en       we_n   done     | cs       grant    b     ad    ab
    add_vec(1'b0, 1'b0, 4'b1010, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 4'b1010, 4'hF, 4'b0000,   4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
    // Phase 1 times out after 10 idle RUN cycles; stray done/Start ignored.
    for (int k = 2; k <= 12; k++)
      add_vec(k == 5, 1'b0, 4'b1010, 4'hF, (k == 5) ? 4'b1001 : 4'b0000,
              4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b1010, 4'hF, 4'b0000,   4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b1010, 4'hF, 4'b0000,   4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b1010, 4'hF, 4'b1000,   4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 4'b1010, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    // Nothing enabled: only an All_done pulse.
    add_vec(1'b1, 1'b0, 4'b0000, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 4'b0000, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    // Abort in idle: no pulse.
    add_vec(1'b0, 1'b1, 4'b0000, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    // Abort during phase 2 RUN; non-owner done ignored first.
    add_vec(1'b1, 1'b0, 4'b0100, 4'hF, 4'b0000,   4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b0100, 4'hF, 4'b0000,   4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b0100, 4'hF, 4'b0010,   4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 4'b0100, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 4'b0100, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    // Restart begins at phase 1; abort in START; Start+Abort in idle.
    add_vec(1'b1, 1'b0, 4'b1110, 4'hF, 4'b0000,   4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 4'b1110, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b1, 4'b1110, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    // Done during S_START is not sampled; the next one ends the phase.
    add_vec(1'b1, 1'b0, 4'b0100, 4'hF, 4'b0000,   4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b0100, 4'hF, 4'b0100,   4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 4'b0100, 4'hF, 4'b0100,   4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 4'b0100, 4'hF, 4'b0000,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);

    // Reset values.
    #12;
    check("reset_status", 32'(status()), 32'({4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0}));
    @(negedge CLOCK_50_I);
    resetn = 1'b1;

    // Table-driven vectors.
    for (int k = 0; k < n_vecs; k++) begin
      start        = vecs[k].start;
      abort        = vecs[k].abort;
      phase_enable = vecs[k].en;
      client_we_n  = vecs[k].we_n;
      client_done  = vecs[k].done;
      tick();
      check($sformatf("vec%0d", k), 32'(status()),
            32'({vecs[k].exp_cs, vecs[k].exp_grant, vecs[k].exp_busy,
                 vecs[k].exp_all_done, vecs[k].exp_aborted}));
    end
    quiet();

    // Full sequence: Start t0, client 1 writes t3, done 2 at t20, done 3 at t30.
    phase_enable = 4'b1110;
    for (int t = 0; t <= 32; t++) begin
      start       = (t == 0);
      client_we_n = (t == 3) ? 4'b1101 : 4'hF;
      client_done = (t == 20) ? 4'b0100 : (t == 30) ? 4'b1000 : 4'b0000;
      tick();
      e_cs = (t + 1 == 1)  ? 4'b0010 :
             (t + 1 == 15) ? 4'b0100 :
             (t + 1 == 21) ? 4'b1000 : 4'b0000;
      e_gr = (t + 1 <= 14) ? 4'b0010 :
             (t + 1 <= 20) ? 4'b0100 :
             (t + 1 <= 30) ? 4'b1000 : 4'b0001;
      e_ad = (t + 1 == 31);
      check($sformatf("seq_t%0d", t + 1), 32'({client_start, grant, all_done}),
            32'({e_cs, e_gr, e_ad}));
    end
    quiet();

    // Bus mux: clients 0..2 all drive we_n low, only the owner may reach SRAM.
    phase_enable = 4'b0100;
    client_we_n  = 4'b1000;
    tick();
    check("mux_idle_addr", 32'(sram_address), 32'(18'h3FFFF));
    check("mux_idle_we",   32'({sram_we_n, sram_write_data}), 32'({1'b1, 16'h0000}));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mux_own2_addr", 32'(sram_address), 32'(18'h01234));
    check("mux_own2_we",   32'({sram_we_n, sram_write_data}), 32'({1'b0, 16'hBEEF}));
    tick();
    client_done = 4'b0100;
    tick();
    client_done = 4'b0000;
    check("mux_back_addr", 32'(sram_address), 32'(18'h3FFFF));
    check("mux_back_we",   32'({sram_we_n, sram_write_data, all_done}), 32'({1'b1, 16'h0000, 1'b1}));
    quiet();

    // Asynchronous reset in the middle of phase 2.
    phase_enable = 4'b0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async", 32'(status()), 32'({4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0}));
    tick();
    check("rst_held", 32'(status()), 32'({4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0}));
    resetn = 1'b1;
    tick();
    check("rst_no_start", 32'(status()), 32'({4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0}));
    phase_enable = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_restart", 32'(status()), 32'({4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
